// File: rtl/tp_pkg.sv
// Shared encodings and 7-segment constants for the word-class result display.
package tp_pkg;

  localparam int unsigned W_TIPO  = 2;
  localparam int unsigned W_SEG   = 7;
  localparam int unsigned W_CONT  = 4;
  localparam int unsigned N_TIPOS = 4;

  localparam logic [W_TIPO-1:0] TIPO_NULO = 2'b00;
  localparam logic [W_TIPO-1:0] TIPO_ADJ  = 2'b01;
  localparam logic [W_TIPO-1:0] TIPO_COMP = 2'b10;
  localparam logic [W_TIPO-1:0] TIPO_ADV  = 2'b11;

  typedef enum logic [2:0] {
    ESPERA     = 3'd0,
    RESULTADO  = 3'd1,
    CONTA_NULO = 3'd2,
    CONTA_ADJ  = 3'd3,
    CONTA_COMP = 3'd4,
    CONTA_ADV  = 3'd5
  } estado_t;

  // Segments are {g,f,e,d,c,b,a}, active high.
  localparam logic [W_SEG-1:0] SEG_APAGADO = 7'b0000000;
  localparam logic [W_SEG-1:0] SEG_TRACO   = 7'b1000000;
  localparam logic [W_SEG-1:0] SEG_E       = 7'b1111001;
  localparam logic [W_SEG-1:0] SEG_A       = 7'b1110111;
  localparam logic [W_SEG-1:0] SEG_C       = 7'b0111001;
  localparam logic [W_SEG-1:0] SEG_D       = 7'b1011110;

  localparam logic [W_SEG-1:0] SEG_0 = 7'b0111111;
  localparam logic [W_SEG-1:0] SEG_1 = 7'b0000110;
  localparam logic [W_SEG-1:0] SEG_2 = 7'b1011011;
  localparam logic [W_SEG-1:0] SEG_3 = 7'b1001111;
  localparam logic [W_SEG-1:0] SEG_4 = 7'b1100110;
  localparam logic [W_SEG-1:0] SEG_5 = 7'b1101101;
  localparam logic [W_SEG-1:0] SEG_6 = 7'b1111101;
  localparam logic [W_SEG-1:0] SEG_7 = 7'b0000111;
  localparam logic [W_SEG-1:0] SEG_8 = 7'b1111111;
  localparam logic [W_SEG-1:0] SEG_9 = 7'b1101111;

  // Decoder request: letters use valor = tipo zero-extended; any other letter value is a dash.
  typedef struct packed {
    logic              digito;
    logic [W_CONT-1:0] valor;
  } glifo_t;

  localparam logic [W_CONT-1:0] VALOR_TRACO = 4'hF;
  localparam logic [W_CONT-1:0] CONT_MAX    = 4'd9;

  function automatic logic [W_CONT-1:0] inc_sat(input logic [W_CONT-1:0] v);
    return (v >= CONT_MAX) ? CONT_MAX : v + W_CONT'(1);
  endfunction

endpackage

// File: rtl/resultado_display_if.sv
// Classifier-to-display link: result inputs, view button, segment and pulse outputs.
interface resultado_display_if;
  import tp_pkg::*;

  logic              fim;
  logic [W_TIPO-1:0] tipo;
  logic              ver;
  logic [W_SEG-1:0]  display;
  logic              novo;

  modport master (output fim, tipo, ver, input display, novo);
  modport slave  (input fim, tipo, ver, output display, novo);

endinterface

// File: rtl/decod_7seg.sv
// Combinational glyph decoder: letter (by tipo) or decimal digit to 7 segments.
module decod_7seg
  import tp_pkg::*;
(
  input  glifo_t           glifo,
  output logic [W_SEG-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_TRACO;
    if (glifo.digito) begin
      case (glifo.valor)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_TRACO;
      endcase
    end else begin
      case (glifo.valor)
        {2'b00, TIPO_NULO}: seg_c = SEG_E;
        {2'b00, TIPO_ADJ}:  seg_c = SEG_A;
        {2'b00, TIPO_COMP}: seg_c = SEG_C;
        {2'b00, TIPO_ADV}:  seg_c = SEG_D;
        default:            seg_c = SEG_TRACO;
      endcase
    end
  end

endmodule

// File: rtl/resultado_display.sv
// Result display: latches the classifier's word class, blinks it, and optionally cycles
// through per-class counters (compile with CONTADORES_EN to enable the counters and views).
module resultado_display
  import tp_pkg::*;
#(
  parameter int unsigned MEIO_PERIODO = 4,
  parameter int unsigned N_PISCAS     = 3
) (
  input  logic               clk,
  input  logic               reset,
  resultado_display_if.slave bus
);

  localparam int unsigned W_MEIO   = 8;
  localparam int unsigned W_PISCAS = 4;
  localparam logic [W_MEIO-1:0]   MEIO_ULT   = W_MEIO'(MEIO_PERIODO - 1);
  localparam logic [W_PISCAS-1:0] PISCAS_ULT = W_PISCAS'(N_PISCAS - 1);

  logic              fim_q;
  logic              captura_c;
  logic [W_TIPO-1:0] ultimo_tipo;
  logic              novo_q;
  estado_t           estado;
  estado_t           estado_nxt;

  logic                blink_ativo;
  logic                fase_on;
  logic [W_MEIO-1:0]   meio_cnt;
  logic [W_PISCAS-1:0] piscas_cnt;

  glifo_t           glifo_c;
  logic [W_SEG-1:0] seg_c;
  logic [W_SEG-1:0] display_nxt_c;
  logic [W_SEG-1:0] display_q;

  assign captura_c = bus.fim & ~fim_q;

`ifdef CONTADORES_EN
  logic              ver_q;
  logic              ver_ev_c;
  logic [W_CONT-1:0] cont [N_TIPOS];

  // ver is sampled every cycle, so an event coinciding with a capture is simply lost.
  always_ff @(posedge clk) begin
    if (reset) ver_q <= 1'b0;
    else       ver_q <= bus.ver;
  end

  assign ver_ev_c = bus.ver & ~ver_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_TIPOS; i++) cont[i] <= '0;
    end else if (captura_c) begin
      cont[bus.tipo] <= inc_sat(cont[bus.tipo]);
    end
  end
`else
  logic unused_ver;
  assign unused_ver = bus.ver;
`endif

  // Capture path: edge sample, class latch and one-cycle novo pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      fim_q       <= 1'b0;
      ultimo_tipo <= TIPO_NULO;
      novo_q      <= 1'b0;
    end else begin
      fim_q  <= bus.fim;
      novo_q <= captura_c;
      if (captura_c) ultimo_tipo <= bus.tipo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) estado <= ESPERA;
    else       estado <= estado_nxt;
  end

  always_comb begin
    estado_nxt = estado;
    if (captura_c) begin
      estado_nxt = RESULTADO;
    end
`ifdef CONTADORES_EN
    else if (ver_ev_c) begin
      case (estado)
        RESULTADO:  estado_nxt = CONTA_NULO;
        CONTA_NULO: estado_nxt = CONTA_ADJ;
        CONTA_ADJ:  estado_nxt = CONTA_COMP;
        CONTA_COMP: estado_nxt = CONTA_ADV;
        CONTA_ADV:  estado_nxt = RESULTADO;
        default:    estado_nxt = estado;
      endcase
    end
`endif
  end

  always_comb begin
    glifo_c = '{digito: 1'b0, valor: VALOR_TRACO};
    case (estado)
      RESULTADO:  glifo_c = '{digito: 1'b0, valor: W_CONT'(ultimo_tipo)};
`ifdef CONTADORES_EN
      CONTA_NULO: glifo_c = '{digito: 1'b1, valor: cont[0]};
      CONTA_ADJ:  glifo_c = '{digito: 1'b1, valor: cont[1]};
      CONTA_COMP: glifo_c = '{digito: 1'b1, valor: cont[2]};
      CONTA_ADV:  glifo_c = '{digito: 1'b1, valor: cont[3]};
`endif
      default:    glifo_c = '{digito: 1'b0, valor: VALOR_TRACO};
    endcase
  end

  // Blink timer: off/on half-periods, counted in pairs; a new capture restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_ativo <= 1'b0;
      fase_on     <= 1'b0;
      meio_cnt    <= '0;
      piscas_cnt  <= '0;
    end else if (captura_c) begin
      blink_ativo <= 1'b1;
      fase_on     <= 1'b0;
      meio_cnt    <= '0;
      piscas_cnt  <= '0;
    end else if (blink_ativo) begin
      if (meio_cnt == MEIO_ULT) begin
        meio_cnt <= '0;
        if (!fase_on) begin
          fase_on <= 1'b1;
        end else begin
          fase_on <= 1'b0;
          if (piscas_cnt == PISCAS_ULT) blink_ativo <= 1'b0;
          else                          piscas_cnt  <= piscas_cnt + W_PISCAS'(1);
        end
      end else begin
        meio_cnt <= meio_cnt + W_MEIO'(1);
      end
    end
  end

  decod_7seg u_decod (
    .glifo (glifo_c),
    .seg_c (seg_c)
  );

  assign display_nxt_c = (blink_ativo && !fase_on) ? SEG_APAGADO : seg_c;

  always_ff @(posedge clk) begin
    if (reset) display_q <= SEG_TRACO;
    else       display_q <= display_nxt_c;
  end

  assign bus.display = display_q;
  assign bus.novo    = novo_q;

endmodule
